// File: rtl/mdio_cmd_sched.sv
// Command scheduler in front of a Clause-22 MDIO master: buffers host register
// commands, runs them one at a time on the master and returns one response each.
module mdio_cmd_sched #(
  parameter int FIFO_DEPTH     = 4,
  parameter int GAP_CYCLES     = 256,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [15:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        mdio_start,
  output logic [1:0]  mdio_opcode,
  output logic [4:0]  mdio_phy_addr,
  output logic [4:0]  mdio_reg_addr,
  output logic [15:0] mdio_wdata,
  input  logic        mdio_done,
  input  logic [15:0] mdio_rdata
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int ENT_W = 27;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    LOAD = 5'b00010,
    RUN  = 5'b00100,
    RESP = 5'b01000,
    GAP  = 5'b10000
  } state_t;

  state_t state, state_nxt;

  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_nxt;
  logic             push, pop;

  logic [ENT_W-1:0] head;
  logic             head_write;
  logic [4:0]       head_phy;
  logic [4:0]       head_reg;
  logic [15:0]      head_wdata;

  logic             done_meta_p0, done_sync_p1, done_sync_p2;
  logic             done_rise;

  logic [TMR_W-1:0] timer;
  logic [GAP_W-1:0] gap_cnt;
  logic             cap_pend;
  logic             is_write;

  logic             start_set, run_done, run_tmo, rsp_show, rsp_take;

  assign push = cmd_valid & cmd_ready;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // cmd_ready is a register so the host sees a clean, glitch-free full flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_nxt;
      cmd_ready <= (count_nxt != FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_write, cmd_phy, cmd_reg, cmd_wdata};
  end

  assign head       = fifo_mem[rd_ptr];
  assign head_write = head[26];
  assign head_phy   = head[25:21];
  assign head_reg   = head[20:16];
  assign head_wdata = head[15:0];

  // transfer_end comes from the mdc domain: two-flop synchronizer, then edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_meta_p0 <= 1'b0;
      done_sync_p1 <= 1'b0;
      done_sync_p2 <= 1'b0;
    end else begin
      done_meta_p0 <= mdio_done;
      done_sync_p1 <= done_meta_p0;
      done_sync_p2 <= done_sync_p1;
    end
  end

  assign done_rise = done_sync_p1 & ~done_sync_p2;
  assign is_write  = (mdio_opcode == 2'b01);
  assign busy      = (state != IDLE) | (count != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    start_set = 1'b0;
    run_done  = 1'b0;
    run_tmo   = 1'b0;
    rsp_show  = 1'b0;
    rsp_take  = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        start_set = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        // a done edge in the same cycle as the timeout still counts as success
        if (done_rise) begin
          run_done  = 1'b1;
          state_nxt = RESP;
        end else if (timer == TMO_LAST) begin
          run_tmo   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (!rsp_valid) begin
          rsp_show = 1'b1;
        end else if (rsp_ready) begin
          rsp_take  = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdio_start    <= 1'b0;
      mdio_opcode   <= 2'b00;
      mdio_phy_addr <= 5'd0;
      mdio_reg_addr <= 5'd0;
      mdio_wdata    <= 16'd0;
      timer         <= '0;
      gap_cnt       <= '0;
      cap_pend      <= 1'b0;
    end else begin
      if (pop) begin
        mdio_opcode   <= head_write ? 2'b01 : 2'b10;
        mdio_phy_addr <= head_phy;
        mdio_reg_addr <= head_reg;
        mdio_wdata    <= head_wdata;
      end
      if (start_set) begin
        mdio_start <= 1'b1;
        timer      <= '0;
      end else if (state == RUN) begin
        timer <= timer + 1'b1;
      end
      if (run_done) cap_pend <= 1'b1;
      if (rsp_show) begin
        mdio_start <= 1'b0;
        cap_pend   <= 1'b0;
      end
      if (rsp_take) begin
        gap_cnt <= GAP_LAST;
      end else if ((state == GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  // Read data is sampled one cycle after done_rise, when the master's shift
  // register has been static for several mdc periods.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= 16'd0;
      rsp_timeout <= 1'b0;
    end else begin
      if (run_tmo) begin
        rsp_rdata   <= 16'hFFFF;
        rsp_timeout <= 1'b1;
      end
      if (rsp_show) begin
        rsp_valid <= 1'b1;
        rsp_write <= is_write;
        if (cap_pend) begin
          rsp_rdata   <= is_write ? 16'd0 : mdio_rdata;
          rsp_timeout <= 1'b0;
        end
      end
      if (rsp_take) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mdio_cmd_sched.sv
// Bench for mdio_cmd_sched: PHY register-file reference model, MDIO master model
// and a response scoreboard checked by an independent monitor.
module tb_mdio_cmd_sched;

  localparam int FIFO_DEPTH     = 4;
  localparam int GAP_CYCLES     = 256;
  localparam int TIMEOUT_CYCLES = 16384;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [4:0]  cmd_phy = 5'd0;
  logic [4:0]  cmd_reg = 5'd0;
  logic [15:0] cmd_wdata = 16'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_write;
  logic [15:0] rsp_rdata;
  logic        rsp_timeout;
  logic        busy;
  logic        mdio_start;
  logic [1:0]  mdio_opcode;
  logic [4:0]  mdio_phy_addr;
  logic [4:0]  mdio_reg_addr;
  logic [15:0] mdio_wdata;
  logic        mdio_done = 1'b0;
  logic [15:0] mdio_rdata = 16'd0;

  mdio_cmd_sched #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .GAP_CYCLES(GAP_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout), .busy(busy),
    .mdio_start(mdio_start), .mdio_opcode(mdio_opcode),
    .mdio_phy_addr(mdio_phy_addr), .mdio_reg_addr(mdio_reg_addr),
    .mdio_wdata(mdio_wdata), .mdio_done(mdio_done), .mdio_rdata(mdio_rdata)
  );

  always #10 clk = ~clk;

  typedef struct {
    bit        wr;
    bit [4:0]  phy;
    bit [4:0]  rg;
    bit [15:0] wd;
    bit        hang;
    int        delay;
  } tx_t;

  typedef struct {
    bit        wr;
    bit [15:0] rdata;
    bit        tmo;
  } rsp_t;

  tx_t  tx_q[$];
  rsp_t exp_q[$];
  logic [15:0] ref_mem [32][32];
  logic [15:0] phy_mem [32][32];

  int errors = 0;
  int checks = 0;
  int rdy_mode = 0;
  int start_rises = 0;
  int rsp_seen = 0;
  int cur_rsp_hi = 0;
  int last_rsp_hi = 0;

  function automatic logic [15:0] init_val(int p, int r);
    if (p == 1 && r == 2) return 16'h0141;
    if (p == 3 && r == 3) return 16'hBEEF;
    return 16'((p << 8) ^ (r * 16'h0111) ^ 16'h5A00);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: a PHY register file updated in command order
  task automatic send(bit wr, bit [4:0] phy, bit [4:0] rg, bit [15:0] wd, bit hang, int delay);
    int   n;
    bit   accepted;
    tx_t  t;
    rsp_t e;
    n = 0;
    accepted = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_phy   = phy;
    cmd_reg   = rg;
    cmd_wdata = wd;
    while (!accepted && n < 40000) begin
      @(negedge clk);
      if (cmd_ready) accepted = 1;
      else n++;
    end
    if (accepted) begin
      t.wr = wr; t.phy = phy; t.rg = rg; t.wd = wd; t.hang = hang; t.delay = delay;
      e.wr = wr;
      if (hang) begin
        e.rdata = 16'hFFFF;
        e.tmo   = 1'b1;
      end else if (wr) begin
        ref_mem[phy][rg] = wd;
        e.rdata = 16'h0000;
        e.tmo   = 1'b0;
      end else begin
        e.rdata = ref_mem[phy][rg];
        e.tmo   = 1'b0;
      end
      tx_q.push_back(t);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("cmd_accept", accepted, 1);
  endtask

  task automatic wait_idle(string name, int limit);
    int n;
    n = 0;
    while ((busy || rsp_valid || exp_q.size() != 0) && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, n < limit, 1);
  endtask

  initial begin : rdy_drv
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ($urandom_range(0, 3) != 0);
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // MDIO master model: checks the issued frame fields and plays the PHY
  initial begin : master
    tx_t cur;
    int  cnt, hold, hi_len, lo_len;
    bit  active, prev, have_fall, pend_fall;
    cur.hang = 0; cur.wr = 0; cur.phy = 0; cur.rg = 0; cur.wd = 0; cur.delay = 0;
    cnt = 0; hold = 0; hi_len = 0; lo_len = 0;
    active = 0; prev = 0; have_fall = 0; pend_fall = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mdio_done = 1'b0;
        active = 0; hold = 0; prev = 0; have_fall = 0; hi_len = 0; lo_len = 0;
        cur.hang = 0;
      end else begin
        if (mdio_start && !prev) begin
          start_rises++;
          chk("tx_pending", tx_q.size() != 0, 1);
          if (have_fall) begin
            if (pend_fall) chk("gap_len", lo_len, GAP_CYCLES + 2 + last_rsp_hi);
            else           chk("gap_min", lo_len >= GAP_CYCLES + 3, 1);
          end
          if (tx_q.size() != 0) begin
            cur = tx_q.pop_front();
            chk("opcode", mdio_opcode, cur.wr ? 2'b01 : 2'b10);
            chk("phy_addr", mdio_phy_addr, cur.phy);
            chk("reg_addr", mdio_reg_addr, cur.rg);
            if (cur.wr) chk("wdata", mdio_wdata, cur.wd);
            active = !cur.hang;
            cnt = cur.delay;
          end else begin
            active = 0;
            cur.hang = 0;
          end
          hi_len = 0;
        end
        if (!mdio_start && prev) begin
          if (cur.hang) chk("tmo_len", hi_len >= TIMEOUT_CYCLES && hi_len <= TIMEOUT_CYCLES + 2, 1);
          have_fall = 1;
          pend_fall = (tx_q.size() != 0);
          lo_len = 0;
        end
        if (mdio_start) hi_len++;
        else            lo_len++;
        if (active) begin
          if (cnt == 0) begin
            if (cur.wr) phy_mem[mdio_phy_addr][mdio_reg_addr] = mdio_wdata;
            else        mdio_rdata = phy_mem[mdio_phy_addr][mdio_reg_addr];
            mdio_done = 1'b1;
            hold = 60;
            active = 0;
            chk("start_at_done", mdio_start, 1);
          end else begin
            cnt--;
          end
        end else if (hold > 0) begin
          hold--;
          if (hold == 0) mdio_done = 1'b0;
        end
        prev = mdio_start;
      end
    end
  end

  // Response monitor: pops the scoreboard on every handshake
  initial begin : monitor
    bit          held, prev_v;
    logic [17:0] snap;
    rsp_t        e;
    held = 0; prev_v = 0; snap = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        held = 0;
        prev_v = 0;
      end else begin
        if (rsp_valid && !prev_v) cur_rsp_hi = 0;
        if (rsp_valid) begin
          cur_rsp_hi++;
          if (held) chk("rsp_stable", {rsp_write, rsp_timeout, rsp_rdata}, snap);
          if (rsp_ready) begin
            last_rsp_hi = cur_rsp_hi;
            rsp_seen++;
            chk("rsp_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("rsp_write", rsp_write, e.wr);
              chk("rsp_rdata", rsp_rdata, e.rdata);
              chk("rsp_timeout", rsp_timeout, e.tmo);
            end
            held = 0;
          end else begin
            held = 1;
            snap = {rsp_write, rsp_timeout, rsp_rdata};
          end
        end
        prev_v = rsp_valid;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  initial begin : main
    int r0, s0;
    for (int p = 0; p < 32; p++)
      for (int r = 0; r < 32; r++) begin
        ref_mem[p][r] = init_val(p, r);
        phy_mem[p][r] = init_val(p, r);
      end

    #2 rst = 1'b0;
    #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_fields", {rsp_write, rsp_timeout, rsp_rdata}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", mdio_start, 0);
    chk("rst_mdio_fields", {mdio_opcode, mdio_phy_addr, mdio_reg_addr, mdio_wdata}, 0);
    idle(3);
    rst = 1'b1;
    idle(2);

    // single write with a full-length frame
    send(1, 5'h01, 5'h00, 16'h1140, 0, 6400);
    wait_idle("drain_write", 10000);

    // single read followed by a queued write
    send(0, 5'h01, 5'h02, 16'h0000, 0, 1500);
    send(1, 5'h02, 5'h05, 16'hA5A5, 0, 900);
    wait_idle("drain_read", 10000);

    // burst: one in flight plus four buffered fills the FIFO
    for (int i = 0; i < 5; i++)
      send($urandom_range(0, 1), 5'h02, 5'($urandom_range(0, 7)), 16'($urandom), 0,
           $urandom_range(600, 900));
    chk("burst_full", cmd_ready, 0);
    chk("burst_busy", busy, 1);
    send(0, 5'h02, 5'h01, 16'h0000, 0, 700);
    wait_idle("drain_burst", 15000);

    // hung transfer followed by a normal one
    send(0, 5'h04, 5'h01, 16'h0000, 1, 0);
    send(1, 5'h04, 5'h01, 16'h3C3C, 0, 700);
    wait_idle("drain_timeout", 25000);

    // backpressure on a read of BEEF
    rdy_mode = 2;
    send(0, 5'h03, 5'h03, 16'h0000, 0, 800);
    s0 = 0;
    while (!rsp_valid && s0 < 5000) begin
      @(posedge clk);
      #1;
      s0++;
    end
    chk("bp_rsp_arrived", rsp_valid, 1);
    r0 = start_rises;
    send(1, 5'h00, 5'h07, 16'h1234, 0, 300);
    send(0, 5'h00, 5'h07, 16'h0000, 0, 300);
    idle(1000);
    chk("bp_no_new_start", start_rises, r0);
    chk("bp_valid_held", rsp_valid, 1);
    chk("bp_rdata_held", rsp_rdata, 16'hBEEF);
    rdy_mode = 0;
    wait_idle("drain_bp", 10000);

    // randomized traffic with random response backpressure
    rdy_mode = 1;
    for (int i = 0; i < 12; i++) begin
      send($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           16'($urandom), 0, $urandom_range(100, 800));
      idle($urandom_range(0, 300));
    end
    wait_idle("drain_random", 20000);
    rdy_mode = 0;
    idle(2);

    // reset in the middle of a transaction with two commands queued
    send(0, 5'h01, 5'h02, 16'h0000, 0, 5000);
    send(0, 5'h01, 5'h02, 16'h0000, 0, 5000);
    send(0, 5'h01, 5'h02, 16'h0000, 0, 5000);
    s0 = 0;
    while (!mdio_start && s0 < 100) begin
      @(posedge clk);
      #1;
      s0++;
    end
    chk("rst_test_started", mdio_start, 1);
    idle(50);
    #3 rst = 1'b0;
    exp_q.delete();
    tx_q.delete();
    #1;
    chk("midrst_start", mdio_start, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_rsp_valid", rsp_valid, 0);
    r0 = start_rises;
    s0 = rsp_seen;
    idle(3);
    rst = 1'b1;
    idle(500);
    chk("post_rst_no_start", start_rises, r0);
    chk("post_rst_no_rsp", rsp_seen, s0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_start_low", mdio_start, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
